shift_deser: RTL
================

Name: shift_deser

Overview:
Serial-to-parallel receiver. It is the receiving end of the LSB-first right-shifting serial stream our shift registers emit on Shift_Out. It collects WIDTH bits framed by a start marker into a word, then presents the word on a valid/ready output holding stage. It sits between a serializing register chain and a downstream consumer, such as the multiplier control path or a display latch. It flags overruns and aborted frames.

Parameters:
WIDTH, 8, word length in bits (2..32)
CNT_W, $clog2(WIDTH), width of the bit counter

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Serial_In  in  1  serial data bit, LSB first
Serial_En  in  1  Serial_In is valid this cycle
Frame_Start  in  1  qualified by Serial_En; this bit is bit 0 of a new word
Out_Ready  in  1  consumer accepts Data_Out this cycle
Clear_Err  in  1  clears the sticky Overrun flag
Data_Out  out  WIDTH  assembled word from the holding register
Out_Valid  out  1  Data_Out holds an unconsumed word
Busy  out  1  a frame is in progress (state SHIFT)
Bit_Count  out  CNT_W  bits received in the current frame
Overrun  out  1  sticky; a completed word was dropped
Abort  out  1  one-cycle pulse; an in-progress frame was restarted

Behaviour:
- One clock domain. Reset is asynchronous and active-high; it affects all flops.
- Reset values: Data_Out=0, Out_Valid=0, Busy=0, Bit_Count=0, Overrun=0, Abort=0. Shift register=0. State=IDLE.
- Shift register SR[WIDTH-1:0]: on each accepted bit, SR <= {Serial_In, SR[WIDTH-1:1]}. After WIDTH bits, the first bit received is at SR[0].
- FSM states: IDLE, SHIFT.
  - IDLE + Serial_En + Frame_Start: shift the bit, Bit_Count=1, go to SHIFT. If WIDTH==1 is disallowed, no completion is possible here.
  - IDLE + Serial_En without Frame_Start: ignore the bit.
  - SHIFT + Serial_En + !Frame_Start: shift, Bit_Count+1.
  - SHIFT + Serial_En + Frame_Start: drop the partial word, pulse Abort for one cycle. Shift this bit as bit 0 (SR gets the new bit, Bit_Count=1), stay in SHIFT.
  - SHIFT + !Serial_En: hold everything. There is no timeout.
- Completion: the accepted bit that makes the count WIDTH completes the word. The next edge writes {Serial_In, SR[WIDTH-1:1]} to the holding stage, returns to IDLE, and sets Bit_Count=0.
  - Latency: Data_Out and Out_Valid are valid one cycle after the last bit's edge, i.e. registered.
- Holding stage handshake:
  - Transfer occurs when Out_Valid && Out_Ready. Out_Valid then drops the next cycle unless a new word loads on the same edge.
  - Out_Ready while Out_Valid=0 has no effect.
  - Data_Out is stable while Out_Valid=1 and not consumed.
- Boundary conditions:
  - Completion while Out_Valid=1 and !Out_Ready: the new word is dropped, the old word is kept, and Overrun is set.
  - Completion on the same edge as a transfer (Out_Valid && Out_Ready): the new word loads, Out_Valid stays 1, no overrun.
  - Clear_Err clears Overrun. If Clear_Err coincides with a new overrun event, set wins.
- Reset mid-frame discards the partial word and the held word immediately, without waiting for a clock edge.
- Bit_Count wraps never: the counter range is 0..WIDTH-1, and it is cleared on completion.

Decomposition:
- Package shift_deser_pkg holds:
  - typedef enum logic {IDLE, SHIFT} deser_state_t
  - localparam DEFAULT_WIDTH=8
- One sub-module, deser_shift_core: a WIDTH-bit right-shift register with Clk, Reset, Shift_En, Clear and Shift_In, giving a parallel output. It is instantiated once. The FSM, counter and holding stage stay in shift_deser.

Test Plan:
1. Basic word: after reset, send 8'hA5 LSB first (1,0,1,0,0,1,0,1) with Frame_Start on the first bit, Out_Ready=1. Required: Data_Out=8'hA5 and Out_Valid=1 for exactly one cycle, one cycle after the 8th bit; Busy high for 8 bits.
2. Backpressure/overrun: Out_Ready=0, send 8'h3C then 8'hFF. Required: Data_Out stays 8'h3C, Overrun=1. Then Out_Ready=1 for one cycle: Out_Valid drops, and Clear_Err clears Overrun.
3. Back-to-back with consume: with 8'h11 held, complete 8'h22 on the same edge as Out_Ready=1. Required: Data_Out=8'h22, Out_Valid stays 1, Overrun=0.
4. Abort: send 3 bits, then Frame_Start with 8 bits of 8'h81. Required: one-cycle Abort pulse, Data_Out=8'h81, no overrun.
5. Gaps and stray bits: Serial_En bits without Frame_Start in IDLE, then 8'h5A with random Serial_En gaps. Required: stray bits ignored, Data_Out=8'h5A, Bit_Count holds during gaps.
6. Async reset: assert Reset mid-frame (Bit_Count=5) and between clock edges while Out_Valid=1. Required: all outputs 0 before the next Clk edge; the next frame of 8'hC3 is received correctly.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
package shift_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deser_shift_core.sv
// WIDTH-bit right-shift register: new bits enter at the MSB, so after WIDTH
// shifts the first bit received sits at bit 0 (LSB-first reassembly).
module deser_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Shift_En,
  input  logic             Clear,
  input  logic             Shift_In,
  output logic [WIDTH-1:0] Data
);

  // Clear has priority so a completed word leaves the register empty.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data <= '0;
    end else if (Clear) begin
      Data <= '0;
    end else if (Shift_En) begin
      Data <= {Shift_In, Data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: frames WIDTH LSB-first bits behind a start
// marker, hands the word to a valid/ready holding stage, and reports
// overruns (sticky) and restarted frames (one-cycle pulse).
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Serial_In,
  input  logic             Serial_En,
  input  logic             Frame_Start,
  input  logic             Out_Ready,
  input  logic             Clear_Err,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Out_Valid,
  output logic             Busy,
  output logic [CNT_W-1:0] Bit_Count,
  output logic             Overrun,
  output logic             Abort
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  deser_state_t     state;
  deser_state_t     state_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word_next;
  logic             shift_en;
  logic             restart;
  logic             complete;
  logic             transfer;

  // A bit is taken when it starts a frame or continues one in progress.
  assign shift_en  = Serial_En && ((state == SHIFT) || Frame_Start);
  assign restart   = (state == SHIFT) && Serial_En && Frame_Start;
  assign complete  = (state == SHIFT) && Serial_En && !Frame_Start &&
                     (Bit_Count == LAST_COUNT);
  assign transfer  = Out_Valid && Out_Ready;
  // The completing bit never lands in sr; the word is taken from the
  // shift input directly so it reaches the holding stage on the same edge.
  assign word_next = {Serial_In, sr[WIDTH-1:1]};
  assign Busy      = (state == SHIFT);

  deser_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .Clk      (Clk),
    .Reset    (Reset),
    .Shift_En (shift_en),
    .Clear    (complete),
    .Shift_In (Serial_In),
    .Data     (sr)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a start marker opens a frame, the WIDTH-th bit closes it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Serial_En && Frame_Start) state_next = SHIFT;
      SHIFT:   if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit counter: a start marker always restarts at 1, completion returns to 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Bit_Count <= '0;
    end else if (shift_en) begin
      if (Frame_Start) begin
        Bit_Count <= CNT_W'(1);
      end else if (complete) begin
        Bit_Count <= '0;
      end else begin
        Bit_Count <= Bit_Count + CNT_W'(1);
      end
    end
  end

  // Abort pulses for one cycle after a frame is restarted mid-word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Abort <= 1'b0;
    end else begin
      Abort <= restart;
    end
  end

  // Holding stage: load when empty or being drained this cycle, else keep.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data_Out  <= '0;
      Out_Valid <= 1'b0;
    end else if (complete && (!Out_Valid || Out_Ready)) begin
      Data_Out  <= word_next;
      Out_Valid <= 1'b1;
    end else if (transfer) begin
      Out_Valid <= 1'b0;
    end
  end

  // Sticky overrun: a dropped word sets it and wins over a coincident clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Overrun <= 1'b0;
    end else if (complete && Out_Valid && !Out_Ready) begin
      Overrun <= 1'b1;
    end else if (Clear_Err) begin
      Overrun <= 1'b0;
    end
  end

endmodule
